ab_gen: RTL and testbench
=========================

# ab_gen

Parametrised address-bus and program-counter generator for the FSM-sequenced 65C2402-family cores. It combines a base (stack, PC, operand bytes or held address) with an index/offset to produce the bus address, and maintains PC and a hold register. Over the fixed 24-bit generator it adds:
- a generic byte count;
- a runtime-selectable wrap width;
- a `rdy` freeze;
- a page-cross fix-up state machine that issues the 6502-style uncorrected dummy address before the corrected one.

It sits between the microcode decoder (`ab_op`) and the memory interface.

## Interface
- `NBYTES`, default 3: address bytes, legal 2..4; AB/PC are 8*NBYTES bits.
- `RESET_PC`, default all-ones minus 5 (24'hfffffa for NBYTES=3): PC after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  1 = advance; 0 = freeze PC, hold, fix register and FSM state.
- `ab_op`  in  11  [10] FX page-fix enable; [9:8] +H; [7] hold capture; [6:5] PC op; [4:3] base select; [2:1] low-byte offset; [0] low carry-in.
- `width_sel`  in  2  active width W: 0 → 2 bytes, 1 → 3, 2/3 → 4; clamped to NBYTES.
- `S`, `DI`, `DR`, `D3`, `D4`, `XY`  in  8 each  stack pointer, data/operand bytes, index.
- `AB`  out  8*NBYTES  bus address; bytes ≥ W always zero.
- `PC`  out  8*NBYTES  program counter, registered.
- `stall`  out  1  1 while a fix-up is pending; the sequencer must hold `ab_op` and operands.

## Operation
- Base select [4:3]:
  - 00: {0…, S}.
  - 01: PC.
  - 10: operand, MSB first over W bytes: W=2 {DI,DR}; W=3 {DI,DR,D3}; W=4 {DI,DR,D3,D4}.
  - 11: hold register.
- Low byte [2:1]: {co,L} = base[7:0] + {0 | XY | DI} + ab_op[0]. Code 11 computes XY + DI + ab_op[0] instead.
- High-byte carry-in hc = ab_op[9] & co. Byte 1 = base[15:8] + {00,01,00,FF} (per [9:8]) + hc.
- Upper bytes 2..W-1:
  - [9:8]=11: base byte + FF + carry (backward, sign-extended).
  - Otherwise: base byte + carry.
- Carry out of byte W-1 is discarded, so addresses wrap modulo 2^(8W).
- Hold: when ab_op[7] and the cycle is effective, hold ← AB.
- PC op [6:5], applied on effective cycles:
  - 00: no change.
  - 01: PC ← (AB+1) mod 2^(8W).
  - 10: PC ← all-ones − 8, masked to W.
  - 11: PC ← all-ones − 2, masked to W.
- Effective cycle: `rdy`=1 and the FSM is not entering FIX.
- FSM states RUN and FIX.
  - RUN, page-cross: if FX=1, [9]=1 and co=1, then AB = uncorrected address (hc forced 0) and stall=1. If `rdy`=1, the corrected address is latched into the fix register and the FSM moves to FIX; PC and hold are not updated this cycle.
  - RUN, otherwise: AB is combinational as above and stall=0.
  - FIX: AB = fix register and stall=0. PC and hold updates are applied using this AB. If `rdy`=1, the FSM returns to RUN; if `rdy`=0, it stays in FIX.
- FX is ignored when [9]=0 or co=0 (no penalty cycle).

## Timing
- AB is combinational from inputs and state (zero-cycle latency). PC, hold, fix register and FSM state are registered.
- Page-cross costs exactly one extra cycle: dummy cycle then corrected cycle. Back-to-back fix-ups are permitted (FIX→RUN→FIX).
- RST asserted, including mid-FIX:
  - Immediately: PC = RESET_PC masked to NBYTES, hold = 0, fix register = 0, state = RUN, stall = 0.
  - AB then follows the RUN equations.
- Reset release is not guarded inside the block; the system synchronises deassertion.
- `rdy`=0 holds every register. AB still tracks inputs (RUN) or the fix register (FIX). In RUN, stall may assert combinationally while `rdy`=0.
- Changing `width_sel` takes effect in the same cycle; PC is re-masked only on its next write.

## Test plan
- Page-cross fix-up (NBYTES=3, W=3):
  - Setup: DI=01, DR=20, D3=F0, XY=20; base=10, +X=01, +H=10, FX=1, PC op=01.
  - Cycle 1: AB=012010, stall=1, PC unchanged.
  - Cycle 2: AB=012110, stall=0.
  - Next edge: PC=012111.
- Backward branch: PC=010005, base=01, +X=10, DI=F0, +H=11 → AB=00FFF5. Repeat with DI=F0 and PC=0100F5 → AB=00FFE5.
- 16-bit wrap: W=2 (NBYTES=3), PC=00FFFF, base=01, PC op=01 → AB=00FFFF; next PC=000000, AB[23:16]=0.
- Vectors and reset:
  - Async RST during FIX → PC=FFFFFA and stall=0 before the next clock edge.
  - PC op=10 with W=3 → PC=FFFFF7; PC op=11 with W=2 → PC=00FFFD.
- `rdy` freeze: with `rdy`=0 in FIX for 3 cycles → PC, hold and AB stable. Raising `rdy` completes the fix-up in one cycle.
- NBYTES=4, W=4: DI=12, DR=34, D3=56, D4=FF; base=10, +X=00, ab_op[0]=1, +H=10 → AB=12345700.

Source files
------------

// File: rtl/ab_gen_if.sv
// Sequencer-to-address-generator bundle: microcode op, operand bytes and the
// resulting bus address / program counter.
//
// Handshake: the generator advances on every rising edge where rdy=1. While
// stall=1 the sequencer keeps ab_op and all operand bytes unchanged; a cycle
// with rdy=1 and stall=1 is the dummy cycle and is always followed by the
// corrected cycle. dbg_fix exposes the fix-up state for observation only.
interface ab_gen_if #(
    parameter int NBYTES = 3
);
    logic                  rdy;
    logic [10:0]           ab_op;
    logic [1:0]            width_sel;
    logic [7:0]            S;
    logic [7:0]            DI;
    logic [7:0]            DR;
    logic [7:0]            D3;
    logic [7:0]            D4;
    logic [7:0]            XY;
    logic [8*NBYTES-1:0]   AB;
    logic [8*NBYTES-1:0]   PC;
    logic                  stall;
    logic                  dbg_fix;

    modport master (
        output rdy, ab_op, width_sel, S, DI, DR, D3, D4, XY,
        input  AB, PC, stall, dbg_fix
    );

    modport slave (
        input  rdy, ab_op, width_sel, S, DI, DR, D3, D4, XY,
        output AB, PC, stall, dbg_fix
    );
endinterface

// File: rtl/ab_gen.sv
// Address-bus and PC generator: base + index with selectable wrap width, hold
// register and a one-cycle page-cross fix-up (dummy address, then corrected).
module ab_gen #(
    parameter int                  NBYTES   = 3,
    parameter logic [8*NBYTES-1:0] RESET_PC = {(8*NBYTES){1'b1}} - (8*NBYTES)'(5)
) (
    input  logic    clk,
    input  logic    RST,
    ab_gen_if.slave bus
);
    localparam int AW = 8 * NBYTES;
    localparam int HW = AW - 8;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_FIX = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_hold;
    logic [AW-1:0]    r_fix;

    logic [2:0]       w_width;
    logic [AW-1:0]    w_mask;
    logic [AW-1:0]    w_operand;
    logic [AW-1:0]    w_base;
    logic [7:0]       w_lo_a;
    logic [7:0]       w_lo_b;
    logic [8:0]       w_lo_sum;
    logic             w_co;
    logic             w_hc;
    logic             w_page_cross;
    logic [HW-1:0]    w_hi_add;
    logic [HW-1:0]    w_hi_raw;
    logic [HW-1:0]    w_hi_cor;
    logic [AW-1:0]    w_ab_uncor;
    logic [AW-1:0]    w_ab_cor;
    logic [AW-1:0]    w_ab;
    logic             w_stall;
    logic             w_enter_fix;
    logic             w_eff;
    logic [AW-1:0]    w_pc_nxt;

    always_comb begin
        case (bus.width_sel)
            2'd0:    w_width = 3'd2;
            2'd1:    w_width = 3'd3;
            default: w_width = 3'd4;
        endcase
        if (w_width > 3'(NBYTES)) begin
            w_width = 3'(NBYTES);
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w_mask[8*i +: 8] = (3'(i) < w_width) ? 8'hff : 8'h00;
        end
    end

    // Operand bytes arrive MSB first, so DI lands in the top active byte.
    always_comb begin
        case (w_width)
            3'd2:    w_operand = AW'({bus.DI, bus.DR});
            3'd3:    w_operand = AW'({bus.DI, bus.DR, bus.D3});
            default: w_operand = AW'({bus.DI, bus.DR, bus.D3, bus.D4});
        endcase
    end

    always_comb begin
        case (bus.ab_op[4:3])
            2'b00:   w_base = {{HW{1'b0}}, bus.S};
            2'b01:   w_base = r_pc;
            2'b10:   w_base = w_operand;
            default: w_base = r_hold;
        endcase
    end

    always_comb begin
        w_lo_a = w_base[7:0];
        w_lo_b = 8'h00;
        case (bus.ab_op[2:1])
            2'b01: w_lo_b = bus.XY;
            2'b10: w_lo_b = bus.DI;
            2'b11: begin
                w_lo_a = bus.XY;
                w_lo_b = bus.DI;
            end
            default: w_lo_b = 8'h00;
        endcase
    end

    assign w_lo_sum     = {1'b0, w_lo_a} + {1'b0, w_lo_b} + {8'h00, bus.ab_op[0]};
    assign w_co         = w_lo_sum[8];
    assign w_hc         = bus.ab_op[9] & w_co;
    assign w_page_cross = bus.ab_op[10] & w_hc;

    // +H=11 adds all-ones across every upper byte: a sign-extended -1 page.
    always_comb begin
        case (bus.ab_op[9:8])
            2'b01:   w_hi_add = HW'(1);
            2'b11:   w_hi_add = {HW{1'b1}};
            default: w_hi_add = '0;
        endcase
    end

    assign w_hi_raw   = w_base[AW-1:8] + w_hi_add;
    assign w_hi_cor   = w_hi_raw + {{(HW-1){1'b0}}, w_hc};
    assign w_ab_uncor = {w_hi_raw, w_lo_sum[7:0]} & w_mask;
    assign w_ab_cor   = {w_hi_cor, w_lo_sum[7:0]} & w_mask;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ab        = w_ab_cor;
        w_stall     = 1'b0;
        w_enter_fix = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_page_cross) begin
                    w_ab    = w_ab_uncor;
                    w_stall = 1'b1;
                    if (bus.rdy) begin
                        w_state_nxt = ST_FIX;
                        w_enter_fix = 1'b1;
                    end
                end
            end
            ST_FIX: begin
                w_ab = r_fix & w_mask;
                if (bus.rdy) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // The dummy cycle only latches the fix register; PC/hold wait for FIX.
    assign w_eff = bus.rdy & ~w_enter_fix;

    always_comb begin
        w_pc_nxt = r_pc;
        case (bus.ab_op[6:5])
            2'b01:   w_pc_nxt = (w_ab + AW'(1)) & w_mask;
            2'b10:   w_pc_nxt = ({AW{1'b1}} - AW'(8)) & w_mask;
            2'b11:   w_pc_nxt = ({AW{1'b1}} - AW'(2)) & w_mask;
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_pc   <= RESET_PC;
            r_hold <= '0;
            r_fix  <= '0;
        end else begin
            if (w_enter_fix) begin
                r_fix <= w_ab_cor;
            end
            if (w_eff) begin
                r_pc <= w_pc_nxt;
                if (bus.ab_op[7]) begin
                    r_hold <= w_ab;
                end
            end
        end
    end

    assign bus.AB      = w_ab;
    assign bus.PC      = r_pc;
    assign bus.stall   = w_stall;
    assign bus.dbg_fix = (r_state == ST_FIX);
endmodule

// File: tb/tb_ab_gen.sv
// Bench for ab_gen: two instances (3-byte and 4-byte) driven by the same
// stimulus, checked against an arithmetic address model plus directed vectors.
module tb_ab_gen;
    logic        clk = 1'b0;
    logic        RST;
    logic        rdy;
    logic [10:0] op;
    logic [1:0]  ws;
    logic [7:0]  s, di, dr, d3, d4, xy;

    always #5 clk = ~clk;

    ab_gen_if #(.NBYTES(3)) bus3 ();
    ab_gen_if #(.NBYTES(4)) bus4 ();

    ab_gen #(.NBYTES(3)) dut3 (.clk(clk), .RST(RST), .bus(bus3));
    ab_gen #(.NBYTES(4)) dut4 (.clk(clk), .RST(RST), .bus(bus4));

    assign bus3.rdy = rdy;  assign bus3.ab_op = op;  assign bus3.width_sel = ws;
    assign bus3.S = s;      assign bus3.DI = di;     assign bus3.DR = dr;
    assign bus3.D3 = d3;    assign bus3.D4 = d4;     assign bus3.XY = xy;
    assign bus4.rdy = rdy;  assign bus4.ab_op = op;  assign bus4.width_sel = ws;
    assign bus4.S = s;      assign bus4.DI = di;     assign bus4.DR = dr;
    assign bus4.D3 = d3;    assign bus4.D4 = d4;     assign bus4.XY = xy;

    // Reference state: index 0 is the 3-byte instance, index 1 the 4-byte one.
    longint      m_pc[2];
    longint      m_hold[2];
    longint      m_fixval[2];
    longint      m_ab[2];
    longint      m_cor[2];
    bit          m_fix[2];
    bit          m_px[2];
    bit          m_st[2];
    bit          last_stall;
    bit          busy;
    logic [31:0] exp_q3[$];
    logic [31:0] exp_q4[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_op(bit fx, logic [1:0] h, bit hold, logic [1:0] pcop,
                                          logic [1:0] base, logic [1:0] off, bit ci);
        return {fx, h, hold, pcop, base, off, ci};
    endfunction

    function automatic int eff_w(int nb);
        int w;
        w = (ws == 2'd0) ? 2 : (ws == 2'd1) ? 3 : 4;
        if (w > nb) w = nb;
        return w;
    endfunction

    function automatic longint byte_mask(int bytes);
        return (longint'(1) << (8 * bytes)) - 1;
    endfunction

    // Address as plain integer arithmetic: low byte sum, then the upper part
    // as one number plus page delta plus carry, wrapped to W-1 bytes.
    function automatic void calc(input int k, output longint a_uncor, output longint a_cor,
                                 output bit co);
        int     nb;
        int     w;
        longint b, la, lb, sum, delta, hi;
        nb = (k == 0) ? 3 : 4;
        w  = eff_w(nb);
        case (op[4:3])
            2'd0: b = longint'(s);
            2'd1: b = m_pc[k];
            2'd2: begin
                if (w == 2)      b = longint'(di) * 256 + longint'(dr);
                else if (w == 3) b = longint'(di) * 65536 + longint'(dr) * 256 + longint'(d3);
                else             b = longint'(di) * 16777216 + longint'(dr) * 65536
                                     + longint'(d3) * 256 + longint'(d4);
            end
            default: b = m_hold[k];
        endcase
        if (op[2:1] == 2'd3) begin
            la = longint'(xy);
            lb = longint'(di);
        end else begin
            la = b % 256;
            lb = (op[2:1] == 2'd0) ? 0 : (op[2:1] == 2'd1) ? longint'(xy) : longint'(di);
        end
        sum   = la + lb + (op[0] ? 1 : 0);
        co    = (sum > 255);
        delta = (op[9:8] == 2'd1) ? 1 : (op[9:8] == 2'd3) ? -1 : 0;
        hi    = (b / 256 + delta) & byte_mask(w - 1);
        a_uncor = hi * 256 + sum % 256;
        hi    = (b / 256 + delta + ((op[9] && co) ? 1 : 0)) & byte_mask(w - 1);
        a_cor = hi * 256 + sum % 256;
    endfunction

    task automatic reset_model();
        m_pc[0] = 64'hFFFFFA;
        m_pc[1] = 64'hFFFFFFFA;
        for (int k = 0; k < 2; k++) begin
            m_hold[k]   = 0;
            m_fixval[k] = 0;
            m_fix[k]    = 1'b0;
        end
        exp_q3.delete();
        exp_q4.delete();
        exp_q3.push_back(32'(m_pc[0]));
        exp_q4.push_back(32'(m_pc[1]));
    endtask

    task automatic check_cycle();
        logic [31:0] ep;
        last_stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            longint u, c;
            bit     co;
            calc(k, u, c, co);
            m_px[k]  = op[10] && op[9] && co;
            m_cor[k] = c;
            if (m_fix[k]) begin
                m_ab[k] = m_fixval[k];
                m_st[k] = 1'b0;
            end else begin
                m_ab[k] = m_px[k] ? u : c;
                m_st[k] = m_px[k];
            end
            if (m_st[k]) last_stall = 1'b1;
        end
        check_val("ab3", 32'(bus3.AB), 32'(m_ab[0]));
        check_val("stall3", 32'(bus3.stall), 32'(m_st[0]));
        ep = exp_q3.pop_front();
        check_val("pc3", 32'(bus3.PC), ep);
        check_val("ab4", bus4.AB, 32'(m_ab[1]));
        check_val("stall4", 32'(bus4.stall), 32'(m_st[1]));
        ep = exp_q4.pop_front();
        check_val("pc4", bus4.PC, ep);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nb;
            int w;
            nb = (k == 0) ? 3 : 4;
            w  = eff_w(nb);
            if (rdy) begin
                if (!m_fix[k] && m_px[k]) begin
                    m_fixval[k] = m_cor[k];
                    m_fix[k]    = 1'b1;
                end else begin
                    if (op[7]) m_hold[k] = m_ab[k];
                    case (op[6:5])
                        2'd1:    m_pc[k] = (m_ab[k] + 1) & byte_mask(w);
                        2'd2:    m_pc[k] = (byte_mask(nb) - 8) & byte_mask(w);
                        2'd3:    m_pc[k] = (byte_mask(nb) - 2) & byte_mask(w);
                        default: m_pc[k] = m_pc[k];
                    endcase
                    m_fix[k] = 1'b0;
                end
            end
        end
        exp_q3.push_back(32'(m_pc[0]));
        exp_q4.push_back(32'(m_pc[1]));
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step();
        #1;
        check_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_bytes(input logic [7:0] v_di, input logic [7:0] v_dr,
                             input logic [7:0] v_d3, input logic [7:0] v_d4, input logic [7:0] v_xy);
        di = v_di; dr = v_dr; d3 = v_d3; d4 = v_d4; xy = v_xy;
    endtask

    initial begin
        logic [10:0] px_op;
        RST = 1'b0;
        rdy = 1'b1;
        op  = '0;
        ws  = 2'd1;
        s   = 8'h00;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        reset_model();
        #2 RST = 1'b1;
        #1;
        check_val("reset_pc3", 32'(bus3.PC), 32'h00FFFFFA);
        check_val("reset_pc4", bus4.PC, 32'hFFFFFFFA);
        check_val("reset_stall", 32'(bus3.stall), 32'h0);
        check_val("reset_state", 32'(bus3.dbg_fix), 32'h0);
        @(posedge clk);
        #1 RST = 1'b0;
        step();

        // Page-cross fix-up, back-to-back repeat, then a rdy freeze in FIX.
        px_op = mk_op(1'b1, 2'b10, 1'b1, 2'b01, 2'b10, 2'b01, 1'b0);
        set_bytes(8'h01, 8'h20, 8'hF0, 8'h00, 8'h20);
        op = px_op;
        #1;
        check_val("px_dummy_ab", 32'(bus3.AB), 32'h012010);
        check_val("px_dummy_stall", 32'(bus3.stall), 32'h1);
        check_val("px_dummy_pc", 32'(bus3.PC), 32'hFFFFFA);
        step();
        check_val("px_fix_ab", 32'(bus3.AB), 32'h012110);
        check_val("px_fix_stall", 32'(bus3.stall), 32'h0);
        step();
        check_val("px_pc", 32'(bus3.PC), 32'h012111);
        check_val("px_again_ab", 32'(bus3.AB), 32'h012010);
        check_val("px_again_stall", 32'(bus3.stall), 32'h1);
        step();
        rdy = 1'b0;
        repeat (3) begin
            #1;
            check_val("freeze_ab", 32'(bus3.AB), 32'h012110);
            check_val("freeze_pc", 32'(bus3.PC), 32'h012111);
            check_val("freeze_state", 32'(bus3.dbg_fix), 32'h1);
            step();
        end
        rdy = 1'b1;
        step();
        check_val("unfreeze_state", 32'(bus3.dbg_fix), 32'h0);
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
        #1;
        check_val("hold_read", 32'(bus3.AB), 32'h012110);
        step();

        // Backward branches from PC=010005 and PC=0100F5.
        set_bytes(8'h01, 8'h00, 8'h04, 8'h00, 8'h00);
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0);
        step();
        check_val("load_pc_a", 32'(bus3.PC), 32'h010005);
        di = 8'hF0;
        op = mk_op(1'b0, 2'b11, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0);
        #1;
        check_val("bwd_ab", 32'(bus3.AB), 32'h00FFF5);
        step();
        set_bytes(8'h01, 8'h00, 8'hF4, 8'h00, 8'h00);
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0);
        step();
        check_val("load_pc_b", 32'(bus3.PC), 32'h0100F5);
        di = 8'hF0;
        op = mk_op(1'b1, 2'b11, 1'b0, 2'b01, 2'b01, 2'b10, 1'b0);
        #1;
        check_val("bwd_dummy_ab", 32'(bus3.AB), 32'h00FFE5);
        check_val("bwd_dummy_stall", 32'(bus3.stall), 32'h1);
        step();
        check_val("bwd_fix_ab", 32'(bus3.AB), 32'h0100E5);
        step();
        check_val("bwd_pc", 32'(bus3.PC), 32'h0100E6);

        // 16-bit wrap and reset-style PC vectors.
        ws = 2'd0;
        set_bytes(8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00);
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0);
        step();
        check_val("w2_load_pc", 32'(bus3.PC), 32'h00FFFF);
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
        #1;
        check_val("w2_ab", 32'(bus3.AB), 32'h00FFFF);
        step();
        check_val("w2_wrap_pc", 32'(bus3.PC), 32'h000000);
        check_val("w2_wrap_ab", 32'(bus3.AB), 32'h000000);
        ws = 2'd1;
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
        step();
        check_val("vec10_w3", 32'(bus3.PC), 32'hFFFFF7);
        ws = 2'd0;
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        step();
        check_val("vec11_w2", 32'(bus3.PC), 32'h00FFFD);

        // Four-byte operand on the wide instance; the narrow one clamps to 3.
        ws = 2'd2;
        set_bytes(8'h12, 8'h34, 8'h56, 8'hFF, 8'h00);
        op = mk_op(1'b0, 2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1);
        #1;
        check_val("w4_ab", bus4.AB, 32'h12345700);
        check_val("w3_clamp_ab", 32'(bus3.AB), 32'h123457);
        step();

        // Asynchronous reset in the middle of a fix-up.
        ws = 2'd1;
        set_bytes(8'h01, 8'h20, 8'hF0, 8'h00, 8'h20);
        op = px_op;
        step();
        check_val("rst_pre_state", 32'(bus3.dbg_fix), 32'h1);
        op = mk_op(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        s  = 8'h33;
        #1 RST = 1'b1;
        #1;
        check_val("rst_fix_pc3", 32'(bus3.PC), 32'hFFFFFA);
        check_val("rst_fix_pc4", bus4.PC, 32'hFFFFFFFA);
        check_val("rst_fix_stall", 32'(bus3.stall), 32'h0);
        check_val("rst_fix_state", 32'(bus3.dbg_fix), 32'h0);
        check_val("rst_fix_ab", 32'(bus3.AB), 32'h000033);
        RST = 1'b0;
        reset_model();
        step();

        // Randomised traffic; operands stay put while a fix-up is pending.
        busy = 1'b0;
        repeat (800) begin
            if (!busy) begin
                op = 11'($urandom_range(0, 2047));
                ws = 2'($urandom_range(0, 3));
                s  = 8'($urandom_range(0, 255));
                set_bytes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)));
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
            busy = m_fix[0] | m_fix[1] | last_stall;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
